// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipe skid stage.
//
// Contents:
//   pipe_state_t : occupancy state of the two-entry stage (EMPTY, ONE, TWO)
//   PIPE_OCC_W   : width of the occupancy output
package pipe_pkg;

    localparam int PIPE_OCC_W = 2;

    // The encoding is chosen to equal the number of held entries, so the
    // occupancy output is a direct decode of the state register.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } pipe_state_t;

endpackage

// File: rtl/pipe_data_reg.sv
// W-bit payload register with load enable and synchronous active-low reset.
//
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous reset, active low; loads RESET_VAL
//   en_i  : load enable
//   d_i   : next value, loaded when en_i=1
//   q_o   : registered value
module pipe_data_reg #(
    parameter int unsigned   W         = 32,
    parameter logic [W-1:0]  RESET_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] data_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            data_q <= RESET_VAL;
        end else if (en_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/pipe_skid_stage.sv
// Two-entry pipeline skid stage: a main (head) register feeding out_data and a
// skid register that catches one extra entry while the downstream stalls.
// in_ready and out_valid are decoded from the state register only, so no
// combinational path exists from in_valid or out_ready to any output.
//
// Handshake: an entry moves on a port in a cycle where valid and ready are both
// 1 at the rising edge; valid is held with stable data until that happens, and
// ready may be asserted independently of valid.
//
// Build option: define PIPE_SKID_PERF_EN to add the stall_cnt port, a
// saturating count of cycles with out_valid=1 and out_ready=0.
//
// Ports:
//   clk       : clock, rising edge
//   reset     : synchronous reset, active low (priority over everything)
//   flush     : drop all held entries this cycle
//   in_valid  / in_ready  / in_data  : upstream handshake and payload
//   out_valid / out_ready / out_data : downstream handshake and head payload
//   occupancy : number of held entries, 0..2 (mirrors the state register)
//   stall_cnt : back-pressure cycle count (PIPE_SKID_PERF_EN only)
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int unsigned  W         = 32,
    parameter logic [W-1:0] RESET_VAL = '0,
    parameter int unsigned  CNT_W     = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [W-1:0]          in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [W-1:0]          out_data,
    output logic [PIPE_OCC_W-1:0] occupancy
`ifdef PIPE_SKID_PERF_EN
    ,
    output logic [CNT_W-1:0]      stall_cnt
`endif
);

    if (W < 1 || CNT_W < 1) begin : g_bad_param
        $error("pipe_skid_stage: W and CNT_W must be at least 1");
    end

    pipe_state_t  state_q;
    pipe_state_t  state_d;
    logic         in_fire;
    logic         out_fire;
    logic         main_en;
    logic         main_from_skid;
    logic         skid_en;
    logic [W-1:0] main_q;
    logic [W-1:0] skid_q;
    logic [W-1:0] main_d;

    assign in_ready  = (state_q != TWO);
    assign out_valid = (state_q != EMPTY);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        main_en        = 1'b0;
        main_from_skid = 1'b0;
        skid_en        = 1'b0;
        case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    main_en = 1'b1;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    // Head leaves and the new entry replaces it in place.
                    main_en = 1'b1;
                end else if (in_fire) begin
                    skid_en = 1'b1;
                    state_d = TWO;
                end else if (out_fire) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                // in_ready is low here, so only the head can move.
                if (out_fire) begin
                    main_en        = 1'b1;
                    main_from_skid = 1'b1;
                    state_d        = ONE;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
        // Flush empties the stage but leaves both data registers untouched;
        // an accepted input this cycle is simply discarded.
        if (flush) begin
            state_d = EMPTY;
            main_en = 1'b0;
            skid_en = 1'b0;
        end
    end

    assign main_d = main_from_skid ? skid_q : in_data;

    pipe_data_reg #(
        .W         (W),
        .RESET_VAL (RESET_VAL)
    ) u_main_reg (
        .clk   (clk),
        .reset (reset),
        .en_i  (main_en),
        .d_i   (main_d),
        .q_o   (main_q)
    );

    pipe_data_reg #(
        .W         (W),
        .RESET_VAL (RESET_VAL)
    ) u_skid_reg (
        .clk   (clk),
        .reset (reset),
        .en_i  (skid_en),
        .d_i   (in_data),
        .q_o   (skid_q)
    );

    assign out_data = main_q;

    always_comb begin
        occupancy = PIPE_OCC_W'(0);
        case (state_q)
            ONE:     occupancy = PIPE_OCC_W'(1);
            TWO:     occupancy = PIPE_OCC_W'(2);
            default: occupancy = PIPE_OCC_W'(0);
        endcase
    end

`ifdef PIPE_SKID_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;

    // Saturating count; flush does not clear it, only reset does.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_valid && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Self-checking bench for pipe_skid_stage: directed scenarios plus a random
// 0..99 stream, with a scoreboard queue fed on accepted inputs and drained
// on delivered outputs.
module tb_pipe_skid_stage;

    localparam int unsigned  W         = 32;
    localparam int unsigned  CNT_W     = 4;
    localparam logic [W-1:0] RESET_VAL = 32'h0BAD_F00D;

    // ---------------- clock / reset ----------------
    logic         clk = 1'b0;
    logic         reset;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic [1:0]   occupancy;
`ifdef PIPE_SKID_PERF_EN
    logic [CNT_W-1:0] stall_cnt;
`endif

    always #5 clk = ~clk;

    pipe_skid_stage #(
        .W         (W),
        .RESET_VAL (RESET_VAL),
        .CNT_W     (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
`ifdef PIPE_SKID_PERF_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;
    int n_pop    = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];

    // Sampled mid-cycle: inputs were driven 1 time unit after the previous
    // rising edge and stay put until the next one.
    always @(negedge clk) begin
        if (!reset) begin
            exp_q.delete();
        end else begin
            check("occupancy", 32'(occupancy), 32'(exp_q.size()));
            if (out_valid && out_ready && exp_q.size() > 0) begin
                check("out_data", out_data, exp_q.pop_front());
                n_pop++;
            end
            if (flush) begin
                exp_q.delete();
            end else if (in_valid && in_ready) begin
                exp_q.push_back(in_data);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        out_ready = 1'b0;
    endtask

    task automatic push(input logic [W-1:0] val, input logic rdy);
        in_valid  = 1'b1;
        in_data   = val;
        out_ready = rdy;
        tick();
        in_valid  = 1'b0;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 8 && occupancy != 2'd0; i++) tick();
        out_ready = 1'b0;
        check("drained", 32'(occupancy), 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int           next_val;
        int           pop_base;
        logic         r0;

        reset = 1'b0;
        idle_inputs();
        tick();
        tick();
        // Reset values are visible while reset is still held low.
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_occupancy", 32'(occupancy), 32'd0);
        check("rst_out_data",  out_data, RESET_VAL);
        reset = 1'b1;
        tick();

        // Single entry: visible the cycle after acceptance.
        push(32'hA5A5_A5A5, 1'b1);
        out_ready = 1'b0;
        check("lat_out_valid", 32'(out_valid), 32'd1);
        check("lat_out_data",  out_data, 32'hA5A5_A5A5);
        check("lat_occupancy", 32'(occupancy), 32'd1);
        drain();

        // Fill to two under back-pressure, then drain in order.
        push(32'h1, 1'b0);
        push(32'h2, 1'b0);
        check("full_occupancy", 32'(occupancy), 32'd2);
        check("full_in_ready",  32'(in_ready),  32'd0);
        check("full_head",      out_data, 32'h1);
        out_ready = 1'b1;
        tick();
        check("drain1_data", out_data, 32'h2);
        check("drain1_occ",  32'(occupancy), 32'd1);
        tick();
        check("drain2_valid", 32'(out_valid), 32'd0);
        check("drain2_occ",   32'(occupancy), 32'd0);
        out_ready = 1'b0;

        // Random stream 0..99 with 50% valid/ready.
        pop_base = n_pop;
        next_val = 0;
        for (int cyc = 0; cyc < 3000 && next_val < 100; cyc++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = W'(next_val);
            out_ready = 1'($urandom_range(0, 1));
            if (cyc % 7 == 0) begin
                r0 = in_ready;
                out_ready = ~out_ready;
                #1;
                check("in_ready_indep", 32'(in_ready), 32'(r0));
                out_ready = ~out_ready;
                #1;
            end
            if (in_valid && in_ready) next_val++;
            tick();
        end
        check("stream_accepted", 32'(next_val), 32'd100);
        drain();
        check("stream_delivered", 32'(n_pop - pop_base), 32'd100);

        // Flush while full with an input offered: everything is dropped.
        push(32'h11, 1'b0);
        push(32'h22, 1'b0);
        check("preflush_occ", 32'(occupancy), 32'd2);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'h33;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_occ",   32'(occupancy), 32'd0);
        check("flush_valid", 32'(out_valid), 32'd0);
        push(32'h7, 1'b0);
        check("postflush_data", out_data, 32'h7);
        check("postflush_occ",  32'(occupancy), 32'd1);
        drain();

        // Flush in state ONE with both handshakes firing: no input survives.
        push(32'h44, 1'b0);
        flush     = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'h55;
        out_ready = 1'b1;
        tick();
        idle_inputs();
        check("flush1_occ", 32'(occupancy), 32'd0);

        // Reset while full wins over a concurrent push.
        push(32'h66, 1'b0);
        push(32'h77, 1'b0);
        reset    = 1'b0;
        in_valid = 1'b1;
        in_data  = 32'h88;
        tick();
        in_valid = 1'b0;
        check("midrst_occ",      32'(occupancy), 32'd0);
        check("midrst_valid",    32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready),  32'd1);
        check("midrst_data",     out_data, RESET_VAL);
`ifdef PIPE_SKID_PERF_EN
        check("midrst_stall", 32'(stall_cnt), 32'd0);
`endif
        reset = 1'b1;
        tick();

`ifdef PIPE_SKID_PERF_EN
        // Stall counter counts, saturates, and ignores flush.
        push(32'h99, 1'b0);
        check("stall_start", 32'(stall_cnt), 32'd0);
        for (int i = 0; i < 5; i++) tick();
        check("stall_5", 32'(stall_cnt), 32'd5);
        for (int i = 0; i < 15; i++) tick();
        check("stall_sat", 32'(stall_cnt), 32'd15);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("stall_flush", 32'(stall_cnt), 32'd15);
        do_reset();
        check("stall_reset", 32'(stall_cnt), 32'd0);
`else
        do_reset();
`endif
        check("final_occ", 32'(occupancy), 32'd0);
        check("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
